// File: rtl/mpa_pkg.sv
// Shared types for the multi-channel DDS phase accumulator.
package mpa_pkg;

    localparam int unsigned PHASE_WIDTH_DEF  = 32;
    localparam int unsigned NUM_CHANNELS_DEF = 8;

    typedef enum logic [1:0] {
        CFG_FREQ       = 2'd0,
        CFG_PHASE_SET  = 2'd1,
        CFG_GLIDE_STEP = 2'd2
    } cfg_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } mpa_state_e;

endpackage

// File: rtl/mpa_glide_slew.sv
// Combinational portamento: moves a frequency word toward its target by one step, clamped.
module mpa_glide_slew #(
    parameter int unsigned PHASE_WIDTH = 32
) (
    input  logic [PHASE_WIDTH-1:0] freq_i,
    input  logic [PHASE_WIDTH-1:0] target_i,
    input  logic [PHASE_WIDTH-1:0] step_i,
    output logic [PHASE_WIDTH-1:0] freq_next_o
);

    always_comb begin
        freq_next_o = target_i;
        // A zero step means jump straight to the target.
        if (step_i != '0) begin
            if (freq_i < target_i) begin
                if ((target_i - freq_i) > step_i) begin
                    freq_next_o = freq_i + step_i;
                end
            end else if (freq_i > target_i) begin
                if ((freq_i - target_i) > step_i) begin
                    freq_next_o = freq_i - step_i;
                end
            end
        end
    end

endmodule

// File: rtl/multi_channel_phase_accumulator.sv
// Time-multiplexed N-voice DDS phase accumulator sharing one adder across all channels.
// Define MPA_GLIDE_EN to add per-voice frequency glide (target/step registers).
module multi_channel_phase_accumulator
    import mpa_pkg::*;
#(
    parameter int unsigned  PHASE_WIDTH  = PHASE_WIDTH_DEF,
    parameter int unsigned  NUM_CHANNELS = NUM_CHANNELS_DEF,
    localparam int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_active_high,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [PHASE_WIDTH-1:0] cfg_data,
    output logic                   phase_valid,
    output logic [CH_W-1:0]        phase_ch,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   phase_wrap,
    output logic                   sweep_done,
    output logic                   overrun
);

    mpa_state_e             state_q, state_d;
    logic [CH_W-1:0]        idx_q, idx_d;
    logic [PHASE_WIDTH-1:0] phase_q [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] phase_d [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] freq_q  [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] freq_d  [NUM_CHANNELS];

    logic                   valid_q, valid_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [PHASE_WIDTH-1:0] out_q, out_d;
    logic                   wrap_q, wrap_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    logic [PHASE_WIDTH:0]   acc_sum;
    logic                   cfg_hit;

`ifdef MPA_GLIDE_EN
    logic [PHASE_WIDTH-1:0] target_q [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] target_d [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] step_q   [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] step_d   [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] slew_freq;

    mpa_glide_slew #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_glide (
        .freq_i      (freq_q[idx_q]),
        .target_i    (target_q[idx_q]),
        .step_i      (step_q[idx_q]),
        .freq_next_o (slew_freq)
    );
`endif

    // The single shared adder, steered by the sweep index.
    assign acc_sum = {1'b0, phase_q[idx_q]} + {1'b0, freq_q[idx_q]};
    assign cfg_hit = cfg_we && (32'(cfg_ch) < NUM_CHANNELS);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        freq_d    = freq_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        ch_d      = ch_q;
        out_d     = out_q;
        wrap_d    = wrap_q;
        overrun_d = overrun_q;
`ifdef MPA_GLIDE_EN
        target_d  = target_q;
        step_d    = step_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (sample_tick) begin
                    overrun_d = 1'b1;
                end
                phase_d[idx_q] = acc_sum[PHASE_WIDTH-1:0];
                valid_d        = 1'b1;
                ch_d           = idx_q;
                out_d          = acc_sum[PHASE_WIDTH-1:0];
                wrap_d         = acc_sum[PHASE_WIDTH];
`ifdef MPA_GLIDE_EN
                freq_d[idx_q]  = slew_freq;
`endif
                if (idx_q == CH_W'(NUM_CHANNELS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Config writes land after the slot update so a note-on overrides the accumulate.
        if (cfg_hit) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_FREQ: begin
`ifdef MPA_GLIDE_EN
                    target_d[cfg_ch] = cfg_data;
`else
                    freq_d[cfg_ch] = cfg_data;
`endif
                end
                CFG_PHASE_SET: begin
                    phase_d[cfg_ch] = cfg_data;
                    if ((state_q == SWEEP) && (cfg_ch == idx_q)) begin
                        out_d  = cfg_data;
                        wrap_d = 1'b0;
                    end
                end
                CFG_GLIDE_STEP: begin
`ifdef MPA_GLIDE_EN
                    step_d[cfg_ch] = cfg_data;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            out_q     <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                phase_q[i]  <= '0;
                freq_q[i]   <= '0;
`ifdef MPA_GLIDE_EN
                target_q[i] <= '0;
                step_q[i]   <= '0;
`endif
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ch_q      <= ch_d;
            out_q     <= out_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            phase_q   <= phase_d;
            freq_q    <= freq_d;
`ifdef MPA_GLIDE_EN
            target_q  <= target_d;
            step_q    <= step_d;
`endif
        end
    end

    assign phase_valid = valid_q;
    assign phase_ch    = ch_q;
    assign phase_out   = out_q;
    assign phase_wrap  = wrap_q;
    assign sweep_done  = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_multi_channel_phase_accumulator.sv
// Bench for multi_channel_phase_accumulator: reference model feeds a scoreboard of expected phases.
module tb_multi_channel_phase_accumulator;
    import mpa_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned N    = 8;
    localparam int unsigned CH_W = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            sample_tick;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [CH_W-1:0] cfg_ch;
    logic [W-1:0]    cfg_data;
    logic            phase_valid;
    logic [CH_W-1:0] phase_ch;
    logic [W-1:0]    phase_out;
    logic            phase_wrap;
    logic            sweep_done;
    logic            overrun;

    multi_channel_phase_accumulator #(
        .PHASE_WIDTH  (W),
        .NUM_CHANNELS (N)
    ) dut (
        .clk             (clk),
        .rst_active_high (rst),
        .sample_tick     (sample_tick),
        .cfg_we          (cfg_we),
        .cfg_sel         (cfg_sel),
        .cfg_ch          (cfg_ch),
        .cfg_data        (cfg_data),
        .phase_valid     (phase_valid),
        .phase_ch        (phase_ch),
        .phase_out       (phase_out),
        .phase_wrap      (phase_wrap),
        .sweep_done      (sweep_done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [W-1:0]    phase;
        logic            wrap;
        logic            done;
    } exp_t;

    typedef struct {
        int           ch;
        logic [W-1:0] freq;
        int           sweeps;
        logic [W-1:0] exp_phase;
        logic         exp_wrap;
    } vec_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_phase  [N];
    logic [W-1:0] m_freq   [N];
    logic [W-1:0] m_target [N];
    logic [W-1:0] m_step   [N];
    logic [W-1:0] last_phase [N];
    logic         last_wrap  [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every valid phase must match the next expected record.
    always @(negedge clk) begin
        if (rst === 1'b0 && phase_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(phase_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("phase_ch",   64'(phase_ch),   64'(mon_e.ch));
                check("phase_out",  64'(phase_out),  64'(mon_e.phase));
                check("phase_wrap", 64'(phase_wrap), 64'(mon_e.wrap));
                check("sweep_done", 64'(sweep_done), 64'(mon_e.done));
                last_phase[phase_ch] = phase_out;
                last_wrap[phase_ch]  = phase_wrap;
            end
        end
    end

    function automatic logic [W-1:0] glide_next(input logic [W-1:0] f, input logic [W-1:0] t,
                                                 input logic [W-1:0] s);
        if (s == 0) return t;
        if (f < t) return (t - f <= s) ? t : f + s;
        if (f > t) return (f - t <= s) ? t : f - s;
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(N); i++) begin
            m_phase[i] = '0; m_freq[i] = '0; m_target[i] = '0; m_step[i] = '0;
        end
        sb.delete();
    endtask

    // Predicts one full sweep; an optional config write lands in channel cch's slot.
    task automatic model_sweep(input int cch, input logic [1:0] csel, input logic [W-1:0] cval);
        exp_t        e;
        logic [W:0]  s;
        for (int i = 0; i < int'(N); i++) begin
            s       = {1'b0, m_phase[i]} + {1'b0, m_freq[i]};
            e.ch    = CH_W'(i);
            e.phase = s[W-1:0];
            e.wrap  = s[W];
            e.done  = (i == int'(N) - 1);
            if (i == cch && csel == CFG_PHASE_SET) begin
                e.phase = cval;
                e.wrap  = 1'b0;
            end
            sb.push_back(e);
            m_phase[i] = e.phase;
`ifdef MPA_GLIDE_EN
            m_freq[i] = glide_next(m_freq[i], m_target[i], m_step[i]);
            if (i == cch && csel == CFG_FREQ) m_target[i] = cval;
`else
            if (i == cch && csel == CFG_FREQ) m_freq[i] = cval;
`endif
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int ch, input logic [W-1:0] data);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = CH_W'(ch); cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        case (sel)
`ifdef MPA_GLIDE_EN
            CFG_FREQ:       m_target[ch] = data;
            CFG_GLIDE_STEP: m_step[ch]   = data;
`else
            CFG_FREQ:       m_freq[ch]   = data;
`endif
            CFG_PHASE_SET:  m_phase[ch]  = data;
            default: ;
        endcase
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
    endtask

    task automatic sweep(input int cch, input logic [1:0] csel, input logic [W-1:0] cval);
        model_sweep(cch, csel, cval);
        pulse_tick();
        if (cch >= 0) begin
            repeat (cch) @(posedge clk);
            #1;
            cfg_we = 1'b1; cfg_sel = csel; cfg_ch = CH_W'(cch); cfg_data = cval;
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},   64'(phase_valid), 64'd0);
        check({tag, "_ch"},      64'(phase_ch),    64'd0);
        check({tag, "_out"},     64'(phase_out),   64'd0);
        check({tag, "_wrap"},    64'(phase_wrap),  64'd0);
        check({tag, "_done"},    64'(sweep_done),  64'd0);
        check({tag, "_overrun"}, 64'(overrun),     64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        logic [W-1:0] glide_exp[5];
        vecs[0] = '{0, 32'h8000_0000, 3, 32'h8000_0000, 1'b0};
        vecs[1] = '{0, 32'h8000_0000, 2, 32'h0000_0000, 1'b1};
        vecs[2] = '{7, 32'h0000_0000, 2, 32'h0000_0000, 1'b0};
        vecs[3] = '{5, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{2, 32'h0000_0003, 4, 32'h0000_000C, 1'b0};
        vecs[5] = '{6, 32'h4000_0000, 4, 32'h0000_0000, 1'b1};
        glide_exp = '{32'd0, 32'd30, 32'd90, 32'd180, 32'd280};

        rst = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_ch = '0; cfg_data = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        model_clear();

        // Each voice gets its own pitch; one sweep yields phase = freq.
        for (int i = 0; i < int'(N); i++) cfg_write(CFG_FREQ, i, W'(i + 1));
        sweep(-1, 2'd0, '0);
`ifndef MPA_GLIDE_EN
        for (int i = 0; i < int'(N); i++) check("basic_phase", 64'(last_phase[i]), 64'(i + 1));

        foreach (vecs[v]) begin
            do_reset();
            cfg_write(CFG_FREQ, vecs[v].ch, vecs[v].freq);
            for (int s = 0; s < vecs[v].sweeps; s++) sweep(-1, 2'd0, '0);
            check("vec_phase", 64'(last_phase[vecs[v].ch]), 64'(vecs[v].exp_phase));
            check("vec_wrap",  64'(last_wrap[vecs[v].ch]),  64'(vecs[v].exp_wrap));
        end
`endif

        // Reserved selector and (without glide) GLIDE_STEP must not disturb a voice.
        do_reset();
        cfg_write(CFG_FREQ, 1, 32'd5);
        cfg_write(2'd3, 1, 32'd99);
        cfg_write(CFG_GLIDE_STEP, 1, 32'd7);
        sweep(-1, 2'd0, '0);
        sweep(-1, 2'd0, '0);
`ifndef MPA_GLIDE_EN
        check("ignored_cfg", 64'(last_phase[1]), 64'd10);
`endif

        // Second tick mid-sweep: flagged, sweep unaffected, flag sticky.
        do_reset();
        check("overrun_clear", 64'(overrun), 64'd0);
        cfg_write(CFG_FREQ, 0, 32'd1);
        model_sweep(-1, 2'd0, '0);
        pulse_tick();
        repeat (2) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("overrun_set", 64'(overrun), 64'd1);
        drain();
        repeat (10) @(posedge clk);
        check("overrun_sticky", 64'(overrun), 64'd1);
        sweep(-1, 2'd0, '0);
        check("overrun_sticky2", 64'(overrun), 64'd1);

        // Tick in the final sweep cycle is also an overrun and starts nothing.
        do_reset();
        model_sweep(-1, 2'd0, '0);
        pulse_tick();
        repeat (7) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("overrun_last", 64'(overrun), 64'd1);
        drain();
        repeat (12) @(posedge clk);

        // Note-on lands in the voice's own slot.
        do_reset();
        cfg_write(CFG_FREQ, 3, 32'd10);
        sweep(3, CFG_PHASE_SET, 32'h1234);
        check("noteon_phase", 64'(last_phase[3]), 64'h1234);
        check("noteon_wrap",  64'(last_wrap[3]),  64'd0);
        sweep(-1, 2'd0, '0);
        check("noteon_next",  64'(last_phase[3]), 64'h123E);

`ifndef MPA_GLIDE_EN
        // Pitch change in the slot uses the old pitch for that update.
        do_reset();
        cfg_write(CFG_FREQ, 2, 32'd5);
        sweep(2, CFG_FREQ, 32'd100);
        check("freq_slot_old", 64'(last_phase[2]), 64'd5);
        sweep(-1, 2'd0, '0);
        check("freq_slot_new", 64'(last_phase[2]), 64'd105);
`endif

        // Reset in the middle of a sweep.
        do_reset();
        cfg_write(CFG_FREQ, 0, 32'd9);
        model_sweep(-1, 2'd0, '0);
        pulse_tick();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        repeat (10) @(posedge clk);
        cfg_write(CFG_FREQ, 0, 32'd9);
        sweep(-1, 2'd0, '0);
`ifndef MPA_GLIDE_EN
        check("post_rst_phase", 64'(last_phase[0]), 64'd9);
`endif

`ifdef MPA_GLIDE_EN
        do_reset();
        cfg_write(CFG_FREQ, 0, 32'd100);
        cfg_write(CFG_GLIDE_STEP, 0, 32'd30);
        for (int s = 0; s < 5; s++) begin
            sweep(-1, 2'd0, '0);
            check("glide_phase", 64'(last_phase[0]), 64'(glide_exp[s]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
